mdu: RTL

- Iterative multiply/divide unit for the integer datapath; executes MULT, MULTU, DIV and DIVU.
- Uses the shared width-bit au adder/subtractor once per iteration; writes results to architectural HI/LO registers.
- Sits beside the ALU in execute. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/au.sv | 23 ++
 rtl/mdu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
// Imported by mdu and its testbench.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    localparam int MDU_WIDTH = 32;

    function automatic int iter_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int ITER_W = iter_bits(MDU_WIDTH);

    function automatic logic op_is_div(input mdu_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/au.sv
// Width-bit adder/subtractor shared by the execute stage; sub_i selects a - b.
// carry_o is the raw carry out, borrow_out_o is set when a subtraction underflows.
module au #(
    parameter int width = 32
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             sub_i,
    output logic [width-1:0] sum_o,
    output logic             carry_o,
    output logic             borrow_out_o
);

    logic [width:0]   full;
    logic [width-1:0] b_eff;

    assign b_eff        = sub_i ? ~b_i : b_i;
    assign full         = {1'b0, a_i} + {1'b0, b_eff} + {{width{1'b0}}, sub_i};
    assign sum_o        = full[width-1:0];
    assign carry_o      = full[width];
    assign borrow_out_o = sub_i & ~full[width];

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed latency: one load edge, width iteration edges, one sign-fix edge.
module mdu
    import mdu_pkg::*;
#(
    parameter int width = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    localparam int              CntW     = iter_bits(width);
    localparam logic [CntW-1:0] LastIter = CntW'(width - 1);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*width-1:0] acc_q, acc_d;
    logic [width-1:0]   opb_q, opb_d;
    logic               a_sign_q, a_sign_d;
    logic               b_sign_q, b_sign_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic               done_q, done_d;
    logic [width-1:0]   hi_q, hi_d;
    logic [width-1:0]   lo_q, lo_d;

    logic               is_div;
    logic [width-1:0]   acc_hi, acc_lo, shifted;
    logic [width-1:0]   au_a, au_b, au_sum;
    logic               au_carry, au_borrow, keep;
    logic               start_dbz, start_signed;
    logic [2*width-1:0] product;
    logic [width-1:0]   quot, rem;

    assign is_div  = op_is_div(op_q);
    assign acc_hi  = acc_q[2*width-1:width];
    assign acc_lo  = acc_q[width-1:0];
    assign shifted = {acc_hi[width-2:0], acc_lo[width-1]};

    // Multiply adds the multiplicand into the upper half when the low bit is set;
    // divide trial-subtracts the divisor from the shifted partial remainder.
    assign au_a = is_div ? shifted : acc_hi;
    assign au_b = (is_div || acc_lo[0]) ? opb_q : '0;

    au #(.width(width)) u_au (
        .a_i          (au_a),
        .b_i          (au_b),
        .sub_i        (is_div),
        .sum_o        (au_sum),
        .carry_o      (au_carry),
        .borrow_out_o (au_borrow)
    );

    // The bit shifted out of the remainder makes the trial value exceed any divisor.
    assign keep = acc_hi[width-1] | ~au_borrow;

    // A zero divisor runs as unsigned so the restoring loop yields all-ones / raw dividend.
    assign start_dbz    = op_is_div(op) && (b == '0);
    assign start_signed = op_is_signed(op) && !start_dbz;

    assign product = (a_sign_q ^ b_sign_q) ? -acc_q  : acc_q;
    assign quot    = (a_sign_q ^ b_sign_q) ? -acc_lo : acc_lo;
    assign rem     = a_sign_q ? -acc_hi : acc_hi;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        a_sign_d   = a_sign_q;
        b_sign_d   = b_sign_q;
        dbz_pend_d = dbz_pend_q;
        dbz_flag_d = dbz_flag_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    a_sign_d   = start_signed & a[width-1];
                    b_sign_d   = start_signed & b[width-1];
                    acc_d      = {{width{1'b0}}, (start_signed & a[width-1]) ? -a : a};
                    opb_d      = (start_signed & b[width-1]) ? -b : b;
                    dbz_pend_d = start_dbz;
                    dbz_flag_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (is_div) begin
                    acc_d = {keep ? au_sum : shifted, acc_lo[width-2:0], keep};
                end else begin
                    acc_d = {au_carry, au_sum, acc_lo[width-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) state_d = FIX;
            end
            FIX: begin
                if (is_div) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = product[2*width-1:width];
                    lo_d = product[width-1:0];
                end
                dbz_flag_d = dbz_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_flag_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            a_sign_q   <= a_sign_d;
            b_sign_q   <= b_sign_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_flag_q <= dbz_flag_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_flag_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
